redundant_alu_checker: RTL and testbench

- Parametrised, pipelined successor of the dual-ALU fault checker.
- Two identical ALU lanes each compute a WIDTH-bit result plus carry/borrow from their own operands and opcode.
- A second stage XOR-compares the lanes and reports the per-transaction mismatch.
- The block keeps a saturating fault counter, a sticky fault flag and a first-fault capture register for the safety monitor in the user area.

---
 rtl/redundant_alu_pkg.sv | 15 +
 rtl/redundant_alu_checker_alu_lane.sv | 59 +++++
 rtl/redundant_alu_checker.sv | 203 ++++++++++++++++++++
 tb/tb_redundant_alu_checker.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redundant_alu_pkg.sv
// Purpose: shared opcode encodings for the redundant ALU checker.
// Latency: n/a (constants only).
// Backpressure: n/a.
package redundant_alu_pkg;

    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] OP_ADD  = 3'b000;
    localparam logic [SEL_W-1:0] OP_SUB  = 3'b001;
    localparam logic [SEL_W-1:0] OP_AND  = 3'b010;
    localparam logic [SEL_W-1:0] OP_OR   = 3'b011;
    localparam logic [SEL_W-1:0] OP_XOR  = 3'b100;
    localparam logic [SEL_W-1:0] OP_PASS = 3'b101;

endpackage

// File: rtl/redundant_alu_checker_alu_lane.sv
// Purpose: one combinational ALU lane (add/sub/and/or/xor/pass) with carry/borrow.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the enclosing pipeline decides when results are captured.
//
// Ports:
//   i_a, i_b  operands          i_sel    opcode (SEL_W bits)
//   o_res     WIDTH-bit result  o_carry  carry (add) / borrow (sub), 0 for logic ops
module alu_lane
    import redundant_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [SEL_W-1:0] i_sel,
    output logic [WIDTH-1:0] o_res,
    output logic             o_carry
);

    // One extra bit on both so bit WIDTH is the carry-out / borrow-out.
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_dif;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_dif = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_res   = w_sum[WIDTH-1:0];
        o_carry = w_sum[WIDTH];
        case (i_sel)
            OP_SUB: begin
                o_res   = w_dif[WIDTH-1:0];
                o_carry = w_dif[WIDTH];
            end
            OP_AND: begin
                o_res   = i_a & i_b;
                o_carry = 1'b0;
            end
            OP_OR: begin
                o_res   = i_a | i_b;
                o_carry = 1'b0;
            end
            OP_XOR: begin
                o_res   = i_a ^ i_b;
                o_carry = 1'b0;
            end
            OP_PASS: begin
                o_res   = i_a;
                o_carry = 1'b0;
            end
            // OP_ADD and the two spare encodings all behave as add.
            default: begin
                o_res   = w_sum[WIDTH-1:0];
                o_carry = w_sum[WIDTH];
            end
        endcase
    end

endmodule

// File: rtl/redundant_alu_checker.sv
// Purpose: dual-lane ALU with lane compare, saturating fault counter, sticky flag, first-fault capture.
// Latency: 2 cycles from accepted input to out_valid when not stalled.
// Backpressure: whole pipe holds when out_valid & !out_ready; in_ready = !out_valid | out_ready.
//
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready, a0/b0/sel0 (lane 0), a1/b1/sel1 (lane 1)      -- operand side
//   out_valid/out_ready, res0/res1, carry0/carry1, diff, carry_diff, mismatch -- result side
//   clr_fault, fault_sticky, fault_count, cap_sel, cap_res0, cap_res1 -- safety monitor side
module redundant_alu_checker
    import redundant_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [SEL_W-1:0] sel0,
    input  logic [SEL_W-1:0] sel1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res0,
    output logic [WIDTH-1:0] res1,
    output logic             carry0,
    output logic             carry1,
    output logic [WIDTH-1:0] diff,
    output logic             carry_diff,
    output logic             mismatch,
    input  logic             clr_fault,
    output logic             fault_sticky,
    output logic [CNT_W-1:0] fault_count,
    output logic [SEL_W-1:0] cap_sel,
    output logic [WIDTH-1:0] cap_res0,
    output logic [WIDTH-1:0] cap_res1
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ---------------- lanes ----------------
    logic [WIDTH-1:0] w_l0_res;
    logic [WIDTH-1:0] w_l1_res;
    logic             w_l0_carry;
    logic             w_l1_carry;

    alu_lane #(.WIDTH(WIDTH)) u_lane0 (
        .i_a     (a0),
        .i_b     (b0),
        .i_sel   (sel0),
        .o_res   (w_l0_res),
        .o_carry (w_l0_carry)
    );

    alu_lane #(.WIDTH(WIDTH)) u_lane1 (
        .i_a     (a1),
        .i_b     (b1),
        .i_sel   (sel1),
        .o_res   (w_l1_res),
        .o_carry (w_l1_carry)
    );

    // ---------------- handshake ----------------
    logic w_advance;
    logic w_xfer;
    logic w_fault;

    logic             r_out_valid;
    logic             r_mismatch;

    assign w_advance = !r_out_valid || out_ready;
    assign w_xfer    = r_out_valid && out_ready;
    assign w_fault   = w_xfer && r_mismatch;
    assign in_ready  = w_advance;

    // ---------------- stage 1 ----------------
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_res0;
    logic [WIDTH-1:0] r_s1_res1;
    logic             r_s1_c0;
    logic             r_s1_c1;
    logic [SEL_W-1:0] r_s1_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_res0 <= '0;
            r_s1_res1 <= '0;
            r_s1_c0   <= 1'b0;
            r_s1_c1   <= 1'b0;
            r_s1_sel  <= '0;
        end else if (w_advance) begin
            // in_valid is only looked at when advancing, so it is ignored while stalled.
            r_s1_vld  <= in_valid;
            r_s1_res0 <= w_l0_res;
            r_s1_res1 <= w_l1_res;
            r_s1_c0   <= w_l0_carry;
            r_s1_c1   <= w_l1_carry;
            r_s1_sel  <= sel0;
        end
    end

    // ---------------- stage 2: compare ----------------
    logic [WIDTH-1:0] w_s1_diff;
    logic             w_s1_cdiff;

    assign w_s1_diff  = r_s1_res0 ^ r_s1_res1;
    assign w_s1_cdiff = r_s1_c0 ^ r_s1_c1;

    logic [WIDTH-1:0] r_res0;
    logic [WIDTH-1:0] r_res1;
    logic             r_c0;
    logic             r_c1;
    logic [WIDTH-1:0] r_diff;
    logic             r_cdiff;
    logic [SEL_W-1:0] r_s2_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_res0      <= '0;
            r_res1      <= '0;
            r_c0        <= 1'b0;
            r_c1        <= 1'b0;
            r_diff      <= '0;
            r_cdiff     <= 1'b0;
            r_mismatch  <= 1'b0;
            r_s2_sel    <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_s1_vld;
            r_res0      <= r_s1_res0;
            r_res1      <= r_s1_res1;
            r_c0        <= r_s1_c0;
            r_c1        <= r_s1_c1;
            r_diff      <= w_s1_diff;
            r_cdiff     <= w_s1_cdiff;
            // Gated by valid so a bubble can never look like a fault.
            r_mismatch  <= r_s1_vld && ((w_s1_diff != '0) || w_s1_cdiff);
            r_s2_sel    <= r_s1_sel;
        end
    end

    // ---------------- fault accounting ----------------
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_cap_sel;
    logic [WIDTH-1:0] r_cap_res0;
    logic [WIDTH-1:0] r_cap_res1;

    // Clear is applied before the fault of the same cycle: the fault then
    // sees an empty counter and an unset sticky flag.
    logic [CNT_W-1:0] w_cnt_base;
    logic             w_sticky_base;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_cnt_base    = clr_fault ? '0 : r_cnt;
    assign w_sticky_base = clr_fault ? 1'b0 : r_sticky;
    assign w_cnt_next    = (w_cnt_base == CNT_MAX) ? CNT_MAX : (w_cnt_base + {{(CNT_W-1){1'b0}}, 1'b1});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky   <= 1'b0;
            r_cnt      <= '0;
            r_cap_sel  <= '0;
            r_cap_res0 <= '0;
            r_cap_res1 <= '0;
        end else if (w_fault) begin
            r_sticky <= 1'b1;
            r_cnt    <= w_cnt_next;
            if (!w_sticky_base) begin
                r_cap_sel  <= r_s2_sel;
                r_cap_res0 <= r_res0;
                r_cap_res1 <= r_res1;
            end
        end else if (clr_fault) begin
            r_sticky   <= 1'b0;
            r_cnt      <= '0;
            r_cap_sel  <= '0;
            r_cap_res0 <= '0;
            r_cap_res1 <= '0;
        end
    end

    // ---------------- outputs ----------------
    assign out_valid    = r_out_valid;
    assign res0         = r_res0;
    assign res1         = r_res1;
    assign carry0       = r_c0;
    assign carry1       = r_c1;
    assign diff         = r_diff;
    assign carry_diff   = r_cdiff;
    assign mismatch     = r_mismatch;
    assign fault_sticky = r_sticky;
    assign fault_count  = r_cnt;
    assign cap_sel      = r_cap_sel;
    assign cap_res0     = r_cap_res0;
    assign cap_res1     = r_cap_res1;

endmodule

// File: tb/tb_redundant_alu_checker.sv
module tb_redundant_alu_checker;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic         clr_fault;
    logic [W-1:0] a0, b0, a1, b1;
    logic [2:0]   sel0, sel1;

    // main instance (CNT_W = 8)
    logic         in_ready, out_valid, carry0, carry1, carry_diff, mismatch, fault_sticky;
    logic [W-1:0] res0, res1, diff, cap_res0, cap_res1;
    logic [7:0]   fault_count;
    logic [2:0]   cap_sel;

    // saturation instance (CNT_W = 2), same stimulus
    logic         s_in_ready, s_out_valid, s_carry0, s_carry1, s_carry_diff, s_mismatch, s_fault_sticky;
    logic [W-1:0] s_res0, s_res1, s_diff, s_cap_res0, s_cap_res1;
    logic [1:0]   s_fault_count;
    logic [2:0]   s_cap_sel;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    redundant_alu_checker #(.WIDTH(W), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sel0(sel0), .sel1(sel1),
        .out_valid(out_valid), .out_ready(out_ready),
        .res0(res0), .res1(res1), .carry0(carry0), .carry1(carry1),
        .diff(diff), .carry_diff(carry_diff), .mismatch(mismatch),
        .clr_fault(clr_fault), .fault_sticky(fault_sticky), .fault_count(fault_count),
        .cap_sel(cap_sel), .cap_res0(cap_res0), .cap_res1(cap_res1)
    );

    redundant_alu_checker #(.WIDTH(W), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sel0(sel0), .sel1(sel1),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .res0(s_res0), .res1(s_res1), .carry0(s_carry0), .carry1(s_carry1),
        .diff(s_diff), .carry_diff(s_carry_diff), .mismatch(s_mismatch),
        .clr_fault(clr_fault), .fault_sticky(s_fault_sticky), .fault_count(s_fault_count),
        .cap_sel(s_cap_sel), .cap_res0(s_cap_res0), .cap_res1(s_cap_res1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Arithmetic from the opcode definitions on plain integers.
    task automatic ref_alu(input int sel, input int a, input int b, output int r, output int c);
        int s;
        c = 0;
        case (sel)
            1: begin r = (a - b) & 255; c = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a;
            default: begin s = a + b; r = s % 256; c = s / 256; end
        endcase
    endtask

    typedef struct {
        bit v;
        int r0, r1, c0, c1, sel;
    } txn_t;

    txn_t m_pipe[2];          // [0] = newest, [1] = presented at the output
    int   m_cnt8, m_cnt2, m_sticky, m_cap_sel, m_cap_r0, m_cap_r1;

    function automatic bit is_mis(input txn_t t);
        return t.v && ((t.r0 != t.r1) || (t.c0 != t.c1));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) m_pipe[i] = '{0, 0, 0, 0, 0, 0};
        m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0;
        m_cap_sel = 0; m_cap_r0 = 0; m_cap_r1 = 0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        txn_t nt;
        if (chk_en) begin
            chk("out_valid", out_valid, m_pipe[1].v);
            chk("in_ready", in_ready, !m_pipe[1].v || out_ready);
            chk("mismatch", mismatch, is_mis(m_pipe[1]));
            chk("fault_sticky", fault_sticky, m_sticky);
            chk("fault_count", fault_count, m_cnt8);
            chk("sat_fault_count", s_fault_count, m_cnt2);
            chk("cap_sel", cap_sel, m_cap_sel);
            chk("cap_res0", cap_res0, m_cap_r0);
            chk("cap_res1", cap_res1, m_cap_r1);
            if (m_pipe[1].v) begin
                chk("res0", res0, m_pipe[1].r0);
                chk("res1", res1, m_pipe[1].r1);
                chk("carry0", carry0, m_pipe[1].c0);
                chk("carry1", carry1, m_pipe[1].c1);
                chk("diff", diff, m_pipe[1].r0 ^ m_pipe[1].r1);
                chk("carry_diff", carry_diff, m_pipe[1].c0 ^ m_pipe[1].c1);
            end
        end
        // advance the model to the state after the coming posedge
        if (rst) begin
            model_reset();
        end else begin
            if (clr_fault) begin
                m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0;
                m_cap_sel = 0; m_cap_r0 = 0; m_cap_r1 = 0;
            end
            if (out_ready && is_mis(m_pipe[1])) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
                if (m_sticky == 0) begin
                    m_cap_sel = m_pipe[1].sel;
                    m_cap_r0  = m_pipe[1].r0;
                    m_cap_r1  = m_pipe[1].r1;
                end
                m_sticky = 1;
            end
            if (!m_pipe[1].v || out_ready) begin
                nt.v = in_valid;
                nt.sel = int'(sel0);
                ref_alu(int'(sel0), int'(a0), int'(b0), nt.r0, nt.c0);
                ref_alu(int'(sel1), int'(a1), int'(b1), nt.r1, nt.c1);
                m_pipe[1] = m_pipe[0];
                m_pipe[0] = nt;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s0, input logic [W-1:0] xa0, input logic [W-1:0] xb0,
                         input logic [2:0] s1, input logic [W-1:0] xa1, input logic [W-1:0] xb1);
        in_valid = v; sel0 = s0; a0 = xa0; b0 = xb0; sel1 = s1; a1 = xa1; b1 = xb1;
    endtask

    typedef struct {
        logic [2:0]   sel;
        logic [W-1:0] a, b;
        logic [W-1:0] exp_res;
        logic         exp_c;
    } vec_t;

    vec_t vecs[11];

    initial begin : main
        logic [W-1:0] held;
        vecs[0]  = '{3'b000, 8'hF0, 8'h20, 8'h10, 1'b1};
        vecs[1]  = '{3'b001, 8'h05, 8'h07, 8'hFE, 1'b1};
        vecs[2]  = '{3'b001, 8'h07, 8'h05, 8'h02, 1'b0};
        vecs[3]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[4]  = '{3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0};
        vecs[5]  = '{3'b100, 8'hAA, 8'hFF, 8'h55, 1'b0};
        vecs[6]  = '{3'b101, 8'h5A, 8'h11, 8'h5A, 1'b0};
        vecs[7]  = '{3'b110, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[8]  = '{3'b111, 8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[9]  = '{3'b001, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{3'b000, 8'h80, 8'h80, 8'h00, 1'b1};

        rst = 1'b1; out_ready = 1'b1; clr_fault = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00);
        tick(); tick();
        chk_en = 1'b1;
        tick();
        // reset state
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst res0", res0, 0);
        chk("rst count", fault_count, 0);
        rst = 1'b0;
        tick();

        // table-driven, both lanes identical
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].a, vecs[i].b);
            tick();
            in_valid = 1'b0;
            tick();
            chk($sformatf("vec%0d out_valid", i), out_valid, 1);
            chk($sformatf("vec%0d res0", i), res0, vecs[i].exp_res);
            chk($sformatf("vec%0d res1", i), res1, vecs[i].exp_res);
            chk($sformatf("vec%0d carry0", i), carry0, vecs[i].exp_c);
            chk($sformatf("vec%0d carry1", i), carry1, vecs[i].exp_c);
            chk($sformatf("vec%0d mismatch", i), mismatch, 0);
        end
        tick();
        chk("table count", fault_count, 0);

        // single mismatch: lane0 5-1=4, lane1 4-1=3
        drive(1'b1, 3'b001, 8'h05, 8'h01, 3'b001, 8'h04, 8'h01);
        tick();
        in_valid = 1'b0;
        tick();
        chk("mis diff", diff, 8'h07);
        chk("mis flag", mismatch, 1);
        tick();
        chk("mis sticky", fault_sticky, 1);
        chk("mis count", fault_count, 1);
        chk("mis cap_sel", cap_sel, 3'b001);
        chk("mis cap_res0", cap_res0, 8'h04);
        chk("mis cap_res1", cap_res1, 8'h03);

        // stalled mismatch counted once on transfer
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 8'h01, 8'h01, 3'b000, 8'h01, 8'h02);
        tick();
        in_valid = 1'b0;
        tick();
        held = res0;
        drive(1'b1, 3'b100, 8'h33, 8'h44, 3'b100, 8'h33, 8'h44);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall in_ready", in_ready, 0);
            chk("stall out_valid", out_valid, 1);
            chk("stall res0", res0, held);
            chk("stall count", fault_count, 1);
        end
        chk("stall res0 value", held, 8'h02);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("release count", fault_count, 2);
        tick();
        chk("release count once", fault_count, 2);
        chk("release out_valid", out_valid, 0);

        // five mismatching transfers: 8-bit counter 7, 2-bit counter saturates at 3
        drive(1'b1, 3'b100, 8'hFF, 8'h00, 3'b100, 8'hFE, 8'h00);
        for (int k = 0; k < 5; k++) tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("sat count8", fault_count, 7);
        chk("sat count2", s_fault_count, 3);
        chk("sat cap_sel", cap_sel, 3'b001);
        chk("sat cap_res0", cap_res0, 8'h04);
        chk("sat s_cap_res1", s_cap_res1, 8'h03);

        // clear coinciding with a mismatching transfer
        drive(1'b1, 3'b011, 8'hF0, 8'h0F, 3'b011, 8'hF0, 8'h00);
        tick();
        in_valid = 1'b0;
        tick();
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        chk("clr+fault count", fault_count, 1);
        chk("clr+fault count2", s_fault_count, 1);
        chk("clr+fault sticky", fault_sticky, 1);
        chk("clr+fault cap_sel", cap_sel, 3'b011);
        chk("clr+fault cap_res0", cap_res0, 8'hFF);
        chk("clr+fault cap_res1", cap_res1, 8'hF0);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        chk("clr count", fault_count, 0);
        chk("clr sticky", fault_sticky, 0);
        chk("clr cap_sel", cap_sel, 0);
        chk("clr cap_res0", cap_res0, 0);

        // reset with two mismatching sets in flight
        drive(1'b1, 3'b000, 8'h10, 8'h01, 3'b000, 8'h10, 8'h02);
        tick();
        tick();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst-fl out_valid", out_valid, 0);
        chk("rst-fl in_ready", in_ready, 1);
        chk("rst-fl count", fault_count, 0);
        chk("rst-fl sticky", fault_sticky, 0);
        chk("rst-fl res0", res0, 0);
        tick(); tick();
        chk("rst-fl count later", fault_count, 0);
        drive(1'b1, 3'b111, 8'hFF, 8'h01, 3'b111, 8'hFF, 8'h01);
        tick();
        in_valid = 1'b0;
        tick();
        chk("op7 res0", res0, 8'h00);
        chk("op7 carry0", carry0, 1);
        chk("op7 mismatch", mismatch, 0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_fault = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            sel0 = 3'($urandom_range(0, 7));
            a0   = 8'($urandom);
            b0   = 8'($urandom);
            if ($urandom_range(0, 4) != 0) begin
                sel1 = sel0; a1 = a0; b1 = b0;
            end else begin
                sel1 = sel0; a1 = a0 ^ 8'($urandom_range(0, 3)); b1 = 8'($urandom);
            end
            tick();
        end
        rst = 1'b0; clr_fault = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
